// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the peripheral bus arbiter.
package bus_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 64;
    localparam int unsigned DEF_DATA_W = 64;

    // Master slots on the shared bus
    localparam int unsigned MASTER_CPU = 0;
    localparam int unsigned MASTER_GPU = 1;
    localparam int unsigned MASTER_KBD = 2;

    // Read data returned to a master whose access timed out
    localparam logic [DEF_DATA_W-1:0] RDATA_ERR = '1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StTurn
    } state_e;

    // Index width that stays legal for a single master
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side request/grant signals and the shared peripheral bus.
interface bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [NUM_REQ-1:0]        err;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         bus_address;
    logic [DATA_W-1:0]         bus_data_out;
    logic                      bus_data_oe;
    logic                      bus_read;
    logic                      bus_write;
    logic [DATA_W-1:0]         bus_data_in;
    logic                      bus_ack;

    // Arbiter view
    modport slave (
        input  req, req_write, req_addr, req_wdata, bus_data_in, bus_ack,
        output gnt, done, err, rdata, bus_address, bus_data_out, bus_data_oe,
               bus_read, bus_write
    );

    // Masters plus peripherals view
    modport master (
        output req, req_write, req_addr, req_wdata, bus_data_in, bus_ack,
        input  gnt, done, err, rdata, bus_address, bus_data_out, bus_data_oe,
               bus_read, bus_write
    );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin winner select: first request at or after ptr, wrapping.
module rr_picker #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // Scan from the pointer; the first hit wins
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter/sequencer: IDLE -> ACCESS -> TURN.
// Optional access timeout is built when BUS_TIMEOUT_EN is defined.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic           clock,
    input logic           reset,
    bus_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    state_e              state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                oe_q;
    logic                bus_read_q;
    logic                bus_write_q;

    logic [NUM_REQ-1:0]  win_onehot;
    logic [IDX_W-1:0]    win_idx;
    logic                win_any;
    logic                win_write;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_REQ-1:0]  err_q;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (bus.req),
        .ptr    (ptr_q),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (win_any)
    );

    assign win_write = bus.req_write[win_idx];

    // Sequencer: latch the winner's fields on grant so later master changes are ignored
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= IDX_W'(MASTER_CPU);
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            oe_q        <= 1'b0;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_any) begin
                        state_q     <= StAccess;
                        gnt_q       <= win_onehot;
                        addr_q      <= bus.req_addr[32'(win_idx) * ADDR_W +: ADDR_W];
                        wdata_q     <= win_write ?
                                       bus.req_wdata[32'(win_idx) * DATA_W +: DATA_W] : '0;
                        oe_q        <= win_write;
                        bus_read_q  <= !win_write;
                        bus_write_q <= win_write;
                        ptr_q       <= (32'(win_idx) == NUM_REQ - 1) ?
                                       '0 : win_idx + IDX_W'(1);
`ifdef BUS_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                StAccess: begin
                    // An ack on the last counted cycle takes priority over the timeout
                    if (bus.bus_ack) begin
                        if (!bus_write_q) begin
                            rdata_q <= bus.bus_data_in;
                        end
                        done_q      <= gnt_q;
                        gnt_q       <= '0;
                        oe_q        <= 1'b0;
                        bus_read_q  <= 1'b0;
                        bus_write_q <= 1'b0;
                        state_q     <= StTurn;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (32'(cnt_q) == TIMEOUT_CYCLES - 1) begin
                        rdata_q     <= {DATA_W{1'b1}};
                        err_q       <= gnt_q;
                        done_q      <= gnt_q;
                        gnt_q       <= '0;
                        oe_q        <= 1'b0;
                        bus_read_q  <= 1'b0;
                        bus_write_q <= 1'b0;
                        state_q     <= StTurn;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                StTurn: begin
                    done_q  <= '0;
`ifdef BUS_TIMEOUT_EN
                    err_q   <= '0;
`endif
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.done         = done_q;
    assign bus.rdata        = rdata_q;
    assign bus.bus_address  = addr_q;
    assign bus.bus_data_out = wdata_q;
    assign bus.bus_data_oe  = oe_q;
    assign bus.bus_read     = bus_read_q;
    assign bus.bus_write    = bus_write_q;
`ifdef BUS_TIMEOUT_EN
    assign bus.err          = err_q;
`else
    assign bus.err          = '0;
`endif

endmodule
